// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 32-bit ALU between two requesters with a registered response slot
module alu_arbiter #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    input  logic [1:0]         i_req_valid,
    output logic [1:0]         o_req_ready,
    input  logic [63:0]        i_req_op_a,
    input  logic [63:0]        i_req_op_b,
    input  logic [7:0]         i_req_alu_op,
    input  logic [2*TAG_W-1:0] i_req_tag,
    output logic [1:0]         o_rsp_valid,
    input  logic [1:0]         i_rsp_ready,
    output logic [31:0]        o_rsp_data,
    output logic [TAG_W-1:0]   o_rsp_tag,
    output logic               o_rsp_illegal,
    output logic [CNT_W-1:0]   o_grant_cnt0,
    output logic [CNT_W-1:0]   o_grant_cnt1
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_n;
    logic rsp_id, rr_ptr, rsp_pop, can_accept, gsel, accept, illegal;
    logic [1:0] grant;
    logic [31:0] op_a, op_b, alu_res;
    logic [3:0] alu_op;

    // Arbitration, slot next-state and operand steering toward the shared ALU
    always_comb begin
        rsp_pop = state == FULL && i_rsp_ready[rsp_id];
        can_accept = !i_flush && (state == EMPTY || rsp_pop);
        grant = &i_req_valid ? (rr_ptr ? 2'b10 : 2'b01) : i_req_valid;
        gsel = grant[1];
        accept = |grant && can_accept;
        o_req_ready = grant & {2{can_accept && i_rst_n}};
        state_n = i_flush ? EMPTY : accept ? FULL : rsp_pop ? EMPTY : state;
        op_a = gsel ? i_req_op_a[63:32] : i_req_op_a[31:0];
        op_b = gsel ? i_req_op_b[63:32] : i_req_op_b[31:0];
        alu_op = gsel ? i_req_alu_op[7:4] : i_req_alu_op[3:0];
    end

    // Shared ALU; unused opcodes yield zero and flag illegal
    always_comb begin
        alu_res = '0;
        illegal = 1'b0;
        case (alu_op)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a << op_b[4:0];
            4'd2:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            4'd3:    alu_res = {31'd0, op_a < op_b};
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = op_a >> op_b[4:0];
            4'd6:    alu_res = op_a | op_b;
            4'd7:    alu_res = op_a & op_b;
            4'd8:    alu_res = op_a - op_b;
            4'd13:   alu_res = $signed(op_a) >>> op_b[4:0];
            4'd15:   alu_res = op_b;
            default: illegal = 1'b1;
        endcase
    end

    // Slot occupancy register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= EMPTY;
        else state <= state_n;
    end

    // Capture the granted result, owner and tag; advance round-robin and grant counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_data <= '0;
            o_rsp_tag <= '0;
            o_rsp_illegal <= 1'b0;
            rsp_id <= 1'b0;
            rr_ptr <= 1'b0;
            o_grant_cnt0 <= '0;
            o_grant_cnt1 <= '0;
        end else if (accept) begin
            o_rsp_data <= alu_res;
            o_rsp_tag <= gsel ? i_req_tag[TAG_W +: TAG_W] : i_req_tag[0 +: TAG_W];
            o_rsp_illegal <= illegal;
            rsp_id <= gsel;
            rr_ptr <= ~gsel;
            if (!gsel && !(&o_grant_cnt0)) o_grant_cnt0 <= o_grant_cnt0 + 1'b1;
            if (gsel && !(&o_grant_cnt1)) o_grant_cnt1 <= o_grant_cnt1 + 1'b1;
        end
    end

    assign o_rsp_valid = {state == FULL && rsp_id, state == FULL && !rsp_id};
endmodule
